// File: rtl/cplx_pkg.sv
// Shared types and constants for the packed complex operand memory.
// A complex word stores the real part in the upper half and the imaginary
// part in the lower half, both in two's complement.
package cplx_pkg;

    localparam int CPLX_W = 8;

    typedef struct packed {
        logic signed [CPLX_W/2-1:0] re;
        logic signed [CPLX_W/2-1:0] im;
    } cplx_t;

    // Controller state encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Build a packed complex word from its real and imaginary parts
    function automatic cplx_t cplx_pack(input logic signed [CPLX_W/2-1:0] re,
                                        input logic signed [CPLX_W/2-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

endpackage

// File: rtl/cplx_mem_clr_fsm.sv
// Clear sequencer: walks every word of the array writing zero, then opens
// the block for accesses. State is exported so checkers can observe it.
module cplx_mem_clr_fsm
    import cplx_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic [0:0]        state,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    logic [ADDR_W-1:0] clr_ptr;

    // State, clear pointer and ready; reset always restarts the clear at word 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state   <= ST_IDLE;
                        ready   <= 1'b1;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Accesses in this cycle still complete; ready drops at this edge
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        ready   <= 1'b0;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    ready   <= 1'b0;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // While rst is held nothing is written, even though state is CLEAR
    assign clr_we   = (state == ST_CLEAR) && !rst;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/cplx_data_mem.sv
// Complex operand data memory: one write port, two registered read ports,
// a synchronous clear sequencer and a selectable read-during-write policy.
// Handshake: an access is taken on a rising edge when enable and ready are
// both high (read and/or write qualify which access); out_valid is high for
// exactly one cycle after each accepted read, with out_data1/2 holding
// otherwise.
module cplx_data_mem
    import cplx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              read,
    input  logic              write,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] read_address1,
    input  logic [ADDR_W-1:0] read_address2,
    input  logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic              out_valid,
    output logic              ready
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              access_ok;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    cplx_mem_clr_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .state     (state),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    assign access_ok = ready && (state == ST_IDLE);
    assign rd_acc    = enable && read && access_ok;
    assign wr_acc    = enable && write && access_ok && in_range(write_address);

    // Read port 1 data: out-of-range reads return zero, collisions follow WRITE_FIRST
    always_comb begin
        rd1 = '0;
        if (in_range(read_address1)) begin
            if ((WRITE_FIRST != 0) && wr_acc && (read_address1 == write_address))
                rd1 = in_data;
            else
                rd1 = mem[read_address1];
        end
    end

    // Read port 2 data: same policy as port 1, evaluated independently
    always_comb begin
        rd2 = '0;
        if (in_range(read_address2)) begin
            if ((WRITE_FIRST != 0) && wr_acc && (read_address2 == write_address))
                rd2 = in_data;
            else
                rd2 = mem[read_address2];
        end
    end

    // Storage writes: the clear sequencer and the write port never overlap
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_acc)
            mem[write_address] <= in_data;
    end

    // Registered read outputs and their valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data1 <= '0;
            out_data2 <= '0;
            out_valid <= 1'b0;
        end else if (rd_acc) begin
            out_data1 <= rd1;
            out_data2 <= rd2;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cplx_data_mem.sv
// Directed bench for cplx_data_mem. Two instances share all inputs: one
// write-first and one read-first, so collisions can be checked on both.
module tb_cplx_data_mem;
    import cplx_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       read;
    logic       write;
    logic       clear_req;
    logic [7:0] in_data;
    logic [5:0] read_address1;
    logic [5:0] read_address2;
    logic [5:0] write_address;

    logic [7:0] od1_a, od2_a, od1_b, od2_b;
    logic       valid_a, valid_b, ready_a, ready_b;

    int checks   = 0;
    int failures = 0;

    // expected {wf1 port1, wf1 port2, wf0 port1, wf0 port2}
    logic [31:0] exp_q[$];
    logic        rd_pend = 1'b0;
    logic [31:0] held    = '0;
    logic [7:0]  rnd [6];

    cplx_data_mem #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .WRITE_FIRST(1)) dut_wf1 (
        .clk(clk), .rst(rst), .enable(enable), .read(read), .write(write),
        .clear_req(clear_req), .in_data(in_data),
        .read_address1(read_address1), .read_address2(read_address2),
        .write_address(write_address),
        .out_data1(od1_a), .out_data2(od2_a), .out_valid(valid_a), .ready(ready_a)
    );

    cplx_data_mem #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .WRITE_FIRST(0)) dut_wf0 (
        .clk(clk), .rst(rst), .enable(enable), .read(read), .write(write),
        .clear_req(clear_req), .in_data(in_data),
        .read_address1(read_address1), .read_address2(read_address2),
        .write_address(write_address),
        .out_data1(od1_b), .out_data2(od2_b), .out_valid(valid_b), .ready(ready_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rd, input logic wr, input logic cr,
                         input logic [5:0] ra1, input logic [5:0] ra2,
                         input logic [5:0] wa, input logic [7:0] wd);
        enable        = en;
        read          = rd;
        write         = wr;
        clear_req     = cr;
        read_address1 = ra1;
        read_address2 = ra2;
        write_address = wa;
        in_data       = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 8'h00);
    endtask

    task automatic expect_read(input logic [7:0] a1, input logic [7:0] a2,
                               input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({a1, a2, b1, b2});
        rd_pend = 1'b1;
    endtask

    // One clock edge, then check valid and data against the scoreboard
    task automatic step();
        @(posedge clk);
        #1;
        chk("valid_wf1", 32'(valid_a), 32'(rd_pend));
        chk("valid_wf0", 32'(valid_b), 32'(rd_pend));
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                held = exp_q.pop_front();
            end
        end
        chk("data_wf1", {16'h0, od1_a, od2_a}, {16'h0, held[31:16]});
        chk("data_wf0", {16'h0, od1_b, od2_b}, {16'h0, held[15:0]});
        rd_pend = 1'b0;
        idle();
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, "_wf1"}, 32'(ready_a), 32'(exp));
        chk({tag, "_wf0"}, 32'(ready_b), 32'(exp));
    endtask

    task automatic clear_wait(input string tag);
        for (int k = 1; k <= 64; k++) begin
            step();
            chk_ready(tag, k == 64);
        end
    endtask

    initial begin
        logic [7:0] v31, v23;
        v31 = cplx_pack(4'sd3, 4'sd1);
        v23 = cplx_pack(4'sd2, 4'sd3);
        rst = 1'b1;
        idle();

        // Reset held for three cycles
        for (int k = 0; k < 3; k++) begin
            step();
            chk_ready("ready_in_rst", 1'b0);
        end
        rst = 1'b0;

        // Clear after reset; accesses and clear_req during CLEAR are ignored
        for (int k = 1; k <= 64; k++) begin
            if (k <= 60)
                drive(1'b1, 1'b1, 1'b1, k == 30, 6'd6, 6'd6, 6'd6, 8'hEB);
            step();
            chk_ready("ready_clr", k == 64);
        end

        // Cleared boundary words
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd63, 6'd0, 8'h00);
        expect_read(8'h00, 8'h00, 8'h00, 8'h00);
        step();
        step();

        // Write then read two words, then an idle cycle with data held
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, v31);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd1, v23);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd1, 6'd0, 8'h00);
        expect_read(8'h31, 8'h23, 8'h31, 8'h23);
        step();
        step();

        // Write and read while enable=0 are both gated
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd6, 6'd6, 6'd6, 8'hEB);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd6, 6'd6, 6'd0, 8'h00);
        expect_read(8'h00, 8'h00, 8'h00, 8'h00);
        step();

        // Collision on both ports
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd5, 8'h93);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd5, 6'd5, 6'd5, 8'h61);
        expect_read(8'h61, 8'h61, 8'h93, 8'h93);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 6'd5, 6'd0, 8'h00);
        expect_read(8'h61, 8'h61, 8'h61, 8'h61);
        step();

        // Collision on port 1 only
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd7, 6'd5, 6'd7, 8'h7A);
        expect_read(8'h7A, 8'h61, 8'h00, 8'h61);
        step();

        // Random data to addresses 12..17, read back in crossed pairs
        for (int i = 0; i < 6; i++) begin
            rnd[i] = 8'($urandom_range(0, 255));
            drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'(12 + i), rnd[i]);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 6'(12 + i), 6'(17 - i), 6'd0, 8'h00);
            expect_read(rnd[i], rnd[5 - i], rnd[i], rnd[5 - i]);
            step();
        end

        // clear_req with a concurrent read and write: both complete
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd9, v31);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd9, 6'd9, 6'd10, 8'h44);
        expect_read(8'h31, 8'h31, 8'h31, 8'h31);
        step();
        chk_ready("ready_after_req", 1'b0);
        clear_wait("ready_req_clr");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd9, 6'd10, 6'd0, 8'h00);
        expect_read(8'h00, 8'h00, 8'h00, 8'h00);
        step();

        // Reset at clear cycle 20 restarts the sequence
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 8'h00);
        step();
        chk_ready("ready_req2", 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_ready("ready_mid", 1'b0);
        end
        rst  = 1'b1;
        held = '0;
        step();
        step();
        chk_ready("ready_rst2", 1'b0);
        rst = 1'b0;
        clear_wait("ready_rst_clr");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 6'd12, 6'd0, 8'h00);
        expect_read(8'h00, 8'h00, 8'h00, 8'h00);
        step();
        step();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cplx_data_mem.md
Name: cplx_data_mem

Overview:
Parametrised successor of the core's operand data memory, holding packed complex operands (upper half real, lower half imaginary, two's complement). It provides two registered read ports and one write port for the ALU datapath. It replaces the asynchronous power-on preload with a synchronous clear sequencer and a selectable read-during-write policy. Operands are loaded through the normal write port.

Parameters:
DATA_W, 8, word width; must be even (DATA_W/2 bits each for real and imaginary parts)
ADDR_W, 6, address width
DEPTH, 64, number of words; DEPTH <= 2**ADDR_W
WRITE_FIRST, 1, 1 = same-cycle read of the write address returns in_data; 0 = returns old contents

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous active-high; starts the clear sequence
enable  input  1  access qualifier for read/write
read  input  1  perform read on both read ports this cycle
write  input  1  perform write this cycle
clear_req  input  1  one-cycle pulse requesting a full memory clear
in_data  input  DATA_W  write data
read_address1  input  ADDR_W  read port 1 address
read_address2  input  ADDR_W  read port 2 address
write_address  input  ADDR_W  write address
out_data1  output  DATA_W  read port 1 data (registered)
out_data2  output  DATA_W  read port 2 data (registered)
out_valid  output  1  out_data1/2 updated by a read accepted last cycle
ready  output  1  block accepts accesses

Behaviour:
- States: CLEAR, IDLE.
- On rst=1 at a clock edge:
  - state<=CLEAR, clr_ptr<=0.
  - out_data1, out_data2<=0; out_valid<=0; ready<=0.
  - While rst is held, the block stays in CLEAR with clr_ptr=0 and writes nothing.
- CLEAR (rst=0):
  - Each cycle, storage[clr_ptr]<=0 and clr_ptr++.
  - On the cycle that clears DEPTH-1, state<=IDLE and ready<=1 at the same edge.
  - The clear therefore takes exactly DEPTH cycles after rst falls.
  - enable/read/write/clear_req are ignored; out_valid<=0; out_data holds.
- IDLE, accepted read (enable&read&ready):
  - out_dataN<=storage[read_addressN] at the next edge, so latency is 1 cycle; out_valid<=1.
- IDLE, no accepted read:
  - out_valid<=0; out_data1/2 hold their previous value.
- IDLE, accepted write (enable&write&ready): storage[write_address]<=in_data.
- Read/write collision (same address, same cycle):
  - WRITE_FIRST=1: the matching port returns in_data.
  - WRITE_FIRST=0: the matching port returns the old word.
  - The rule applies independently per port; both ports may collide.
- Both read addresses equal: both outputs return the same word.
- clear_req:
  - In IDLE: any access presented in the same cycle completes; state<=CLEAR and ready<=0 at that edge.
  - In CLEAR: ignored; the sequence is not restarted.
- Out-of-range address (>= DEPTH, only possible when DEPTH < 2**ADDR_W): write is dropped; read returns 0 with out_valid=1.
- rst asserted mid-clear or mid-access: the rst rule takes priority and the clear restarts from 0. Contents above clr_ptr are undefined until the clear completes.
- No storage state depends on power-on values; after rst plus DEPTH cycles every word reads 0.

Decomposition:
- Shared package cplx_pkg:
  - CPLX_W, default 8
  - cplx_t packed struct {re, im}, each CPLX_W/2 signed
  - State encoding: ST_CLEAR, ST_IDLE
  - Helper function cplx_pack(re, im)
- Sub-module cplx_mem_clr_fsm: owns state, clr_ptr and ready, and outputs clear write-enable/address to the array.
- The storage array and read muxing stay in cplx_data_mem.

Test Plan:
- Reset clear: rst high 3 cycles, then low → ready=0 for 64 cycles and 1 on cycle 64; reading addresses 0 and 63 gives 8'h00 both, with out_valid=1 one cycle after the request.
- Write then read: write 8'h31 (3+1i) to addr 0 and 8'h23 (2+3i) to addr 1; then read addr1=0, addr2=1 → next cycle out_data1=8'h31, out_data2=8'h23, out_valid=1; the following idle cycle has out_valid=0 and data held.
- Collision: addr 5 holds 8'h93; in the same cycle write 8'h61 to addr 5 and read addr1=5, addr2=5 → WRITE_FIRST=1 gives 8'h61 on both ports, WRITE_FIRST=0 gives 8'h93 on both.
- Gating: enable=0, or during CLEAR, with write of 8'hEB to addr 6 → addr 6 still reads 8'h00 afterwards; out_valid stays 0.
- clear_req: addr 9 holds 8'h31; pulse clear_req together with a read of addr 9 → that read returns 8'h31; ready drops for 64 cycles; afterwards addr 9 reads 8'h00.
- Mid-clear reset: assert rst at clear cycle 20 → clr_ptr restarts from 0; ready rises exactly 64 cycles after rst falls.
